// File: rtl/apb_master_if.sv
// CPU-side request/response and APB bus signals for apb_master.
// The master modport is the block's view; the slave modport is the surrounding system's view.
interface apb_master_if;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        error;
    logic        busy;

    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    modport master (
        input  transfer, write, addr, wdata,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3,
        output rdata, ready, error, busy,
        output PADDR, PWRITE, PENABLE, PWDATA, PSEL
    );

    modport slave (
        output transfer, write, addr, wdata,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3,
        input  rdata, ready, error, busy,
        input  PADDR, PWRITE, PENABLE, PWDATA, PSEL
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master bridging a CPU strobe interface to four 4 KB slave slots,
// with unmapped-address rejection and an ACCESS-phase wait timeout.
module apb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 16
) (
    input logic         PCLK,
    input logic         PRESET,
    apb_master_if.master bus
);

    localparam int NUM_SLOTS = 4;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } req_t;

    state_t state, state_nxt;
    req_t   req_q;
    logic [1:0] idx_q;
    logic [7:0] wait_cnt;
    logic [31:0] rdata_q;
    logic        ready_q, error_q;

    logic [NUM_SLOTS-1:0][31:0] prdata_v;
    logic [NUM_SLOTS-1:0]       pready_v;
    logic [31:0] prdata_sel;
    logic        pready_sel;
    logic        hit, accept;
    logic [NUM_SLOTS-1:0] psel;
    logic        penable, busy;
    logic        done_ok, done_abort;

    assign prdata_v = {bus.PRDATA3, bus.PRDATA2, bus.PRDATA1, bus.PRDATA0};
    assign pready_v = {bus.PREADY3, bus.PREADY2, bus.PREADY1, bus.PREADY0};

    // Only the latched slot is ever observed, so stray responses from other slots are inert.
    assign prdata_sel = prdata_v[idx_q];
    assign pready_sel = pready_v[idx_q];

    assign hit    = (bus.addr[31:14] == BASE_ADDR[31:14]);
    assign accept = (state == IDLE) && bus.transfer;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        psel       = '0;
        penable    = 1'b0;
        busy       = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state)
            IDLE: begin
                if (bus.transfer && hit) state_nxt = SETUP;
            end
            SETUP: begin
                psel[idx_q] = 1'b1;
                busy        = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                psel[idx_q] = 1'b1;
                penable     = 1'b1;
                busy        = 1'b1;
                // A slave answering on the final allowed cycle still wins over the timeout.
                if (pready_sel) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done_abort = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            req_q    <= '0;
            idx_q    <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            ready_q <= done_ok | done_abort | (accept & ~hit);
            error_q <= done_abort | (accept & ~hit);
            if (accept) begin
                req_q <= '{addr: bus.addr, wdata: bus.wdata, write: bus.write};
                idx_q <= bus.addr[13:12];
            end
            if (state == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && !pready_sel)
                wait_cnt <= wait_cnt + 8'd1;
            if (done_ok && !req_q.write)
                rdata_q <= prdata_sel;
        end
    end

    assign bus.PADDR   = req_q.addr;
    assign bus.PWDATA  = req_q.wdata;
    assign bus.PWRITE  = req_q.write;
    assign bus.PSEL    = psel;
    assign bus.PENABLE = penable;
    assign bus.busy    = busy;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a chained vector table plus reset corner sequences.
module tb_apb_master;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_master_if bus();

    apb_master #(.BASE_ADDR(32'h1000_0000), .TIMEOUT(16)) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus.master)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          slot;    // -1 for unmapped
        int          waits;   // ACCESS cycles with PREADY low before it rises
        logic [3:0]  psel;
        int          lat;     // accept cycle to ready cycle
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_ready(input vec_t v, input int acc);
        logic sel_rdy;
        sel_rdy = (acc > v.waits);
        bus.PREADY0 = (v.slot == 0) ? sel_rdy : 1'b1;
        bus.PREADY1 = (v.slot == 1) ? sel_rdy : 1'b1;
        bus.PREADY2 = (v.slot == 2) ? sel_rdy : 1'b1;
        bus.PREADY3 = (v.slot == 3) ? sel_rdy : 1'b1;
    endtask

    // Entered #1 after a rising edge; returns #1 after the edge that made ready visible.
    task automatic run(input vec_t v, input int n);
        int cyc, acc;
        bit done;
        bus.transfer = 1'b1;
        bus.write    = v.wr;
        bus.addr     = v.addr;
        bus.wdata    = v.wdata;
        bus.PRDATA0  = (v.slot == 0) ? v.prdata : 32'hBAD0_0000;
        bus.PRDATA1  = (v.slot == 1) ? v.prdata : 32'hBAD0_0001;
        bus.PRDATA2  = (v.slot == 2) ? v.prdata : 32'hBAD0_0002;
        bus.PRDATA3  = (v.slot == 3) ? v.prdata : 32'hBAD0_0003;
        drive_ready(v, 0);
        @(posedge PCLK); #1;
        bus.transfer = 1'b0;
        bus.addr     = ~v.addr;
        bus.wdata    = ~v.wdata;
        bus.write    = ~v.wr;
        cyc = 1; acc = 0; done = 0;
        while (!done && cyc < 300) begin
            if (bus.ready) begin
                done = 1;
                chk($sformatf("v%0d latency", n), cyc, v.lat);
                chk($sformatf("v%0d error", n), bus.error, v.err);
                chk($sformatf("v%0d rdata", n), bus.rdata, v.rdata);
                chk($sformatf("v%0d psel_done", n), bus.PSEL, 4'b0000);
                chk($sformatf("v%0d busy_done", n), bus.busy, 1'b0);
            end else begin
                if (bus.PENABLE) acc++;
                chk($sformatf("v%0d psel c%0d", n, cyc), bus.PSEL, v.psel);
                chk($sformatf("v%0d penable c%0d", n, cyc), bus.PENABLE, (cyc >= 2));
                chk($sformatf("v%0d busy c%0d", n, cyc), bus.busy, 1'b1);
                chk($sformatf("v%0d paddr c%0d", n, cyc), bus.PADDR, v.addr);
                chk($sformatf("v%0d pwdata c%0d", n, cyc), bus.PWDATA, v.wdata);
                chk($sformatf("v%0d pwrite c%0d", n, cyc), bus.PWRITE, v.wr);
                drive_ready(v, acc);
                @(posedge PCLK); #1;
                cyc++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d no_ready: got none within %0d cycles expected %0d", n, cyc, v.lat);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " PSEL"}, bus.PSEL, 4'b0000);
        chk({tag, " PENABLE"}, bus.PENABLE, 1'b0);
        chk({tag, " busy"}, bus.busy, 1'b0);
        chk({tag, " ready"}, bus.ready, 1'b0);
        chk({tag, " error"}, bus.error, 1'b0);
        chk({tag, " rdata"}, bus.rdata, 32'h0);
        chk({tag, " PADDR"}, bus.PADDR, 32'h0);
        chk({tag, " PWDATA"}, bus.PWDATA, 32'h0);
        chk({tag, " PWRITE"}, bus.PWRITE, 1'b0);
    endtask

    initial begin
        //          wr    addr           wdata          prdata         slot wait psel     lat err   rdata
        tbl[0] = '{1'b1, 32'h1000_0004, 32'h0000_00A5, 32'h0,          0,   0,   4'b0001, 3,  1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h1000_2000, 32'h0,         32'hDEAD_BEEF,  2,   2,   4'b0100, 5,  1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 32'h1000_1008, 32'h0,         32'h7777_7777,  1,   999, 4'b0010, 18, 1'b1, 32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 32'h2000_0000, 32'h0,         32'h0,          -1,  0,   4'b0000, 1,  1'b1, 32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 32'h1000_3010, 32'h0,         32'h1234_5678,  3,   0,   4'b1000, 3,  1'b0, 32'h1234_5678};
        tbl[5] = '{1'b1, 32'h1000_0FFC, 32'h0000_0055, 32'h9999_9999,  0,   1,   4'b0001, 4,  1'b0, 32'h1234_5678};
        tbl[6] = '{1'b0, 32'h1000_1100, 32'h0,         32'hCAFE_F00D,  1,   15,  4'b0010, 18, 1'b0, 32'hCAFE_F00D};
        tbl[7] = '{1'b0, 32'h1000_4000, 32'h0,         32'h0,          -1,  0,   4'b0000, 1,  1'b1, 32'hCAFE_F00D};
        tbl[8] = '{1'b1, 32'h0FFF_F000, 32'h0000_0011, 32'h0,          -1,  0,   4'b0000, 1,  1'b1, 32'hCAFE_F00D};
        tbl[9] = '{1'b0, 32'h1000_0010, 32'h0,         32'h0000_0001,  0,   0,   4'b0001, 3,  1'b0, 32'h0000_0001};

        PRESET       = 1'b0;
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = 32'h1000_0000;
        bus.wdata    = 32'h0;
        bus.PRDATA0  = 32'h0; bus.PRDATA1 = 32'h0; bus.PRDATA2 = 32'h0; bus.PRDATA3 = 32'h0;
        bus.PREADY0  = 1'b1; bus.PREADY1 = 1'b1; bus.PREADY2 = 1'b1; bus.PREADY3 = 1'b1;
        bus.transfer = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        chk_idle_outputs("reset");
        bus.transfer = 1'b0;
        #1 PRESET = 1'b1;

        // Each vector is issued in the ready cycle of the previous one: no dead cycle allowed.
        for (int i = 0; i < 10; i++) run(tbl[i], i);

        // Reset during an ACCESS wait state, then a normal transfer right after release.
        bus.transfer = 1'b1;
        bus.write    = 1'b0;
        bus.addr     = 32'h1000_1000;
        bus.PREADY1  = 1'b0;
        @(posedge PCLK); #1;
        bus.transfer = 1'b0;
        @(posedge PCLK); #1;
        chk("pre_rst PENABLE", bus.PENABLE, 1'b1);
        chk("pre_rst PSEL", bus.PSEL, 4'b0010);
        @(posedge PCLK); #2;
        PRESET = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        #1 PRESET = 1'b1;
        run(tbl[0], 10);
        run(tbl[4], 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
